// File: rtl/vga_vram_arbiter_pkg.sv
// Shared VGA/VRAM constants and the arbiter grant encoding.
// The module parameter defaults are taken from the constants below.
package vga_vram_arbiter_pkg;

    localparam int VGA_HOR_SIZE    = 10;
    localparam int VGA_VER_SIZE    = 10;
    localparam int VRAM_ADDR_W     = 19;
    localparam int VRAM_PIX_W      = 8;
    localparam int VRAM_WORDS      = 307200;
    localparam int VRAM_FIFO_DEPTH = 4;

    // Who owns the RAM port this cycle, and what the host head entry does with it.
    typedef enum logic [2:0] {
        GNT_IDLE,
        GNT_DISP,
        GNT_HOST_WR,
        GNT_HOST_RD,
        GNT_HOST_OOB_RD,
        GNT_HOST_DROP
    } grant_t;

endpackage

// File: rtl/vga_req_fifo.sv
// In-order synchronous FIFO for host requests. The head entry is shown on pop_data.
// An entry pushed in one cycle can be popped in the next cycle at the earliest.
module vga_req_fifo #(
    parameter int WIDTH      = 28,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; only the pointers and count say which slots hold data.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display scan-out reads win whenever the next pixel is
// visible; queued host reads/writes drain only during blanking.
module vga_vram_arbiter
    import vga_vram_arbiter_pkg::*;
#(
    parameter int HOR_SIZE   = VGA_HOR_SIZE,
    parameter int VER_SIZE   = VGA_VER_SIZE,
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int PIX_W      = VRAM_PIX_W,
    parameter int FIFO_DEPTH = VRAM_FIFO_DEPTH,
    parameter int VRAM_WORDS = vga_vram_arbiter_pkg::VRAM_WORDS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [HOR_SIZE-1:0] next_col,
    input  logic [VER_SIZE-1:0] next_row,
    input  logic                visible_next,
    output logic [PIX_W-1:0]    pix_data,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [PIX_W-1:0]    req_wdata,
    output logic                resp_valid,
    output logic [PIX_W-1:0]    resp_rdata,
    output logic                vram_en,
    output logic                vram_we,
    output logic [ADDR_W-1:0]   vram_addr,
    output logic [PIX_W-1:0]    vram_wdata,
    input  logic [PIX_W-1:0]    vram_rdata
);

    localparam int                ENTRY_W   = 1 + ADDR_W + PIX_W;
    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0]   WORDS_LIM = (ADDR_W + 1)'(VRAM_WORDS);

    grant_t              grant;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [ENTRY_W-1:0]  head;
    logic                head_we;
    logic [ADDR_W-1:0]   head_addr;
    logic [PIX_W-1:0]    head_wdata;
    logic                head_in_range;

    logic [ADDR_W-1:0]   scan_q;
    logic [ADDR_W-1:0]   scan_addr;
    logic                frame_start;

    logic [ADDR_W-1:0]   addr_q;
    logic [PIX_W-1:0]    wdata_q;
    logic                disp_rd_q;
    logic                host_rd_q;
    logic                host_oob_q;
    logic [PIX_W-1:0]    resp_rdata_q;

    // ---------------- host request FIFO ----------------
    assign req_ready = reset & (fifo_count < CNT_W'(FIFO_DEPTH));
    assign fifo_push = req_valid & req_ready & ~fifo_full;

    vga_req_fifo #(
        .WIDTH      (ENTRY_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({req_we, req_addr, req_wdata}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_we       = head[ENTRY_W-1];
    assign head_addr     = head[PIX_W +: ADDR_W];
    assign head_wdata    = head[PIX_W-1:0];
    assign head_in_range = ({1'b0, head_addr} < WORDS_LIM);

    // ---------------- scan address ----------------
    // The frame clear acts in the same cycle, so pixel (0,0) is read from address 0.
    assign frame_start = (next_col == '0) && (next_row == '0);
    assign scan_addr   = frame_start ? '0 : scan_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_q <= '0;
        end else if (visible_next) begin
            scan_q <= scan_addr + ADDR_W'(1);
        end else begin
            scan_q <= scan_addr;
        end
    end

    // ---------------- grant ----------------
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant    = GNT_IDLE;
        fifo_pop = 1'b0;
        if (reset) begin
            if (visible_next) begin
                grant = GNT_DISP;
            end else if (!fifo_empty) begin
                fifo_pop = 1'b1;
                if (head_in_range) grant = head_we ? GNT_HOST_WR   : GNT_HOST_RD;
                else               grant = head_we ? GNT_HOST_DROP : GNT_HOST_OOB_RD;
            end
        end
    end

    always_comb begin
        vram_en    = 1'b0;
        vram_we    = 1'b0;
        vram_addr  = addr_q;
        vram_wdata = wdata_q;
        case (grant)
            GNT_DISP: begin
                vram_en   = 1'b1;
                vram_addr = scan_addr;
            end
            GNT_HOST_WR: begin
                vram_en    = 1'b1;
                vram_we    = 1'b1;
                vram_addr  = head_addr;
                vram_wdata = head_wdata;
            end
            GNT_HOST_RD: begin
                vram_en   = 1'b1;
                vram_addr = head_addr;
            end
            default: ;
        endcase
    end

    // ---------------- read return ----------------
    assign pix_data   = (reset && disp_rd_q) ? vram_rdata : '0;
    assign resp_valid = reset & (host_rd_q | host_oob_q);

    always_comb begin
        resp_rdata = resp_rdata_q;
        if (!reset)          resp_rdata = '0;
        else if (host_rd_q)  resp_rdata = vram_rdata;
        else if (host_oob_q) resp_rdata = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            disp_rd_q    <= 1'b0;
            host_rd_q    <= 1'b0;
            host_oob_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            addr_q       <= vram_addr;
            wdata_q      <= vram_wdata;
            disp_rd_q    <= (grant == GNT_DISP);
            host_rd_q    <= (grant == GNT_HOST_RD);
            host_oob_q   <= (grant == GNT_HOST_OOB_RD);
            resp_rdata_q <= resp_rdata;
        end
    end

endmodule
